mips_decode_pipe: RTL

Buffered, handshaked successor to the combinational MIPS arithmetic decoder. It accepts one 32-bit instruction word per cycle over a valid/ready interface and extracts the opcode/funct and register fields. It decodes the arithmetic subset into datapath control and queues the result in an OUT_DEPTH-entry FIFO for the execute stage. An optional exception log counts and captures unrecognised instructions.

---
 rtl/mips_decode_pipe.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/mips_decode_pipe.sv
// Handshaked MIPS arithmetic decoder feeding an OUT_DEPTH-entry FIFO of decoded entries.
// Optional exception log (count / seen / first word) is built when DECODE_EXCEPT_LOG_EN is defined.
module mips_decode_pipe #(
    parameter int OUT_DEPTH = 2,
    parameter int CNT_W     = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [31:0]      i_inst,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic             o_rd_src,
    output logic             o_writeenable,
    output logic [1:0]       o_alu_src2,
    output logic [2:0]       o_alu_op,
    output logic             o_except,
    output logic [4:0]       o_rs_num,
    output logic [4:0]       o_rt_num,
    output logic [4:0]       o_w_num,
    output logic [15:0]      o_imm,
    output logic [CNT_W-1:0] o_except_count,
    output logic             o_except_seen,
    output logic [31:0]      o_first_except_inst
);
    localparam int PTR_W  = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CNT_FW = $clog2(OUT_DEPTH + 1);
    localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(OUT_DEPTH - 1);
    localparam logic [CNT_FW-1:0] FULL_CNT = CNT_FW'(OUT_DEPTH);

    typedef struct packed {
        logic        rd_src;
        logic        we;
        logic [1:0]  src2;
        logic [2:0]  op;
        logic        exc;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  wn;
        logic [15:0] imm;
    } entry_t;

    entry_t              w_dec;
    entry_t              w_head;
    entry_t              r_mem [OUT_DEPTH];
    logic [PTR_W-1:0]    r_head;
    logic [PTR_W-1:0]    r_tail;
    logic [CNT_FW-1:0]   r_count;
    logic                w_push;
    logic                w_pop;
    logic                w_known;
    logic [2:0]          w_op;
    logic [1:0]          w_src2;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        w_known = 1'b0;
        w_op    = 3'd0;
        w_src2  = 2'd0;
        if (i_inst[31:26] == 6'h00) begin
            case (i_inst[5:0])
                6'h20, 6'h21: begin w_known = 1'b1; w_op = 3'd2; end
                6'h22:        begin w_known = 1'b1; w_op = 3'd3; end
                6'h24:        begin w_known = 1'b1; w_op = 3'd4; end
                6'h25:        begin w_known = 1'b1; w_op = 3'd5; end
                6'h26:        begin w_known = 1'b1; w_op = 3'd7; end
                6'h27:        begin w_known = 1'b1; w_op = 3'd6; end
                default:      ;
            endcase
        end else begin
            case (i_inst[31:26])
                6'h08, 6'h09: begin w_known = 1'b1; w_op = 3'd2; w_src2 = 2'd1; end
                6'h0C:        begin w_known = 1'b1; w_op = 3'd4; w_src2 = 2'd2; end
                6'h0D:        begin w_known = 1'b1; w_op = 3'd5; w_src2 = 2'd2; end
                6'h0E:        begin w_known = 1'b1; w_op = 3'd7; w_src2 = 2'd2; end
                default:      ;
            endcase
        end
        // rd_src tracks the instruction format even for unrecognised words
        w_dec.rd_src = (i_inst[31:26] != 6'h00);
        w_dec.we     = w_known;
        w_dec.exc    = ~w_known;
        w_dec.op     = w_op;
        w_dec.src2   = w_src2;
        w_dec.rs     = i_inst[25:21];
        w_dec.rt     = i_inst[20:16];
        w_dec.wn     = w_dec.rd_src ? i_inst[20:16] : i_inst[15:11];
        w_dec.imm    = i_inst[15:0];
    end

    assign o_in_ready  = (r_count < FULL_CNT);
    assign o_out_valid = (r_count != '0);
    assign w_push      = i_in_valid & o_in_ready;
    assign w_pop       = o_out_valid & i_out_ready;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_tail] <= w_dec;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= ptr_inc(r_tail);
            if (w_pop)  r_head <= ptr_inc(r_head);
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
        end
    end

    // Empty FIFO presents an all-zero entry rather than stale storage
    assign w_head        = o_out_valid ? r_mem[r_head] : '0;
    assign o_rd_src      = w_head.rd_src;
    assign o_writeenable = w_head.we;
    assign o_alu_src2    = w_head.src2;
    assign o_alu_op      = w_head.op;
    assign o_except      = w_head.exc;
    assign o_rs_num      = w_head.rs;
    assign o_rt_num      = w_head.rt;
    assign o_w_num       = w_head.wn;
    assign o_imm         = w_head.imm;

`ifdef DECODE_EXCEPT_LOG_EN
    logic [31:0]      r_inst_mem [OUT_DEPTH];
    logic [CNT_W-1:0] r_exc_cnt;
    logic             r_exc_seen;
    logic [31:0]      r_first_inst;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_inst_mem[r_tail] <= i_inst;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_exc_cnt    <= '0;
            r_exc_seen   <= 1'b0;
            r_first_inst <= '0;
        end else if (i_flush) begin
            r_exc_cnt    <= '0;
            r_exc_seen   <= 1'b0;
            r_first_inst <= '0;
        end else if (w_pop && w_head.exc) begin
            if (r_exc_cnt != '1) r_exc_cnt <= r_exc_cnt + CNT_W'(1);
            if (!r_exc_seen) begin
                r_exc_seen   <= 1'b1;
                r_first_inst <= r_inst_mem[r_head];
            end
        end
    end

    assign o_except_count      = r_exc_cnt;
    assign o_except_seen       = r_exc_seen;
    assign o_first_except_inst = r_first_inst;
`else
    assign o_except_count      = '0;
    assign o_except_seen       = 1'b0;
    assign o_first_except_inst = '0;
`endif

endmodule
